operand_entry_fsm: RTL and testbench
====================================

OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, number of consecutive stable clocks required before the debounced key level changes (10 ms at 50 MHz).
REQ-002 Port: clk  input  1  50 MHz system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: sw  input  4  slide-switch operand/op-select value (sw[0] is the op select in the GET_OP state).
REQ-005 Port: key_n  input  1  raw push-button, active-low, asynchronous, bouncy.
REQ-006 Port: a0  output  4  captured first operand, feeding the adder/subtractor a0 input.
REQ-007 Port: a1  output  4  captured second operand, feeding the adder/subtractor a1 input.
REQ-008 Port: s  output  1  captured op select, feeding the adder/subtractor s input (0 add, 1 subtract).
REQ-009 Port: valid  output  1  high while all of a0, a1 and s are committed (state SHOW).
REQ-010 Port: done  output  1  one-cycle pulse on entry to SHOW.
REQ-011 Port: state  output  2  current FSM state for LED display (GET_A=0, GET_B=1, GET_OP=2, SHOW=3).

Function
REQ-012 key_n and sw SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 The debounced key level SHALL update to the synchronized level only after the two have differed for DEBOUNCE_CYCLES consecutive clocks; any return to agreement clears the counter.
REQ-014 A press event SHALL be one clock wide, asserted only on a debounced 1->0 transition; a key held low SHALL produce exactly one press, and release produces no event.
REQ-015 FSM on press: GET_A captures a0<=sync sw and goes to GET_B; GET_B captures a1<=sync sw and goes to GET_OP; GET_OP captures s<=sync sw[0] and goes to SHOW; SHOW goes to GET_A. With no press, the state is held.
REQ-016 valid SHALL equal (state==SHOW) and be registered, with no combinational path from key_n.
REQ-017 done SHALL pulse high for exactly the first cycle in which state==SHOW.
REQ-018 Leaving SHOW SHALL clear valid but retain a0, a1 and s until each is overwritten by its own capture.
REQ-019 Latency with debouncing compiled in: the capture edge is 2+DEBOUNCE_CYCLES clocks after key_n is first sampled low, provided it remains stable.
REQ-020 The value captured SHALL be the synchronized sw at the capture edge; sw changes at any other time have no effect.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL set state=GET_A, a0=0, a1=0, s=0, valid=0 and done=0, clear the debounce counter, and set the synchronizers and debounced level to 1 (released).
REQ-022 Reset asserted mid-entry or in SHOW SHALL discard all captured values, with no press generated on the cycle rst deasserts, even if key_n is held low.

Configuration
REQ-023 The macro OPERAND_ENTRY_DEBOUNCE_EN SHALL control debouncing. When defined, the debounce filter of REQ-013 is included. When undefined, the debounced level equals the synchronized level, no counter exists, DEBOUNCE_CYCLES is ignored, and the capture edge is 2 clocks after key_n is first sampled low.

Verification
REQ-024 Reset: assert rst for 3 cycles -> state=0, a0=0, a1=0, s=0, valid=0, done=0.
REQ-025 Full entry (DEBOUNCE_CYCLES=4): sw=5 then press, sw=2 then press, sw=1 then press -> a0=5, a1=2, s=1, valid=1, state=3, done high for exactly 1 cycle.
REQ-026 Bounce (DEBOUNCE_CYCLES=4): key_n toggles with three low glitches of 2 cycles each, then stays low for 10 cycles -> exactly one capture, state 0->1 only.
REQ-027 Hold: key_n low for 100 cycles, then high -> exactly one state advance.
REQ-028 Reset mid-entry: capture a0=9, then pulse rst with key_n held low -> a0=0, state=0, and no capture until key_n is released and pressed again.
REQ-029 Wrap: press in SHOW with a0=8, a1=3, s=1 -> valid=0, state=0, a0=8, a1=3, s=1 retained.

Source files
------------

// File: rtl/operand_entry_fsm.sv
// Operand entry FSM: this block captures a0, a1 and the op select from the switches, one value per debounced key press.
// The macro OPERAND_ENTRY_DEBOUNCE_EN compiles in the key debounce filter. Without it, the key level is the synchronized level.
module operand_entry_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       key_n,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic       s,
  output logic       valid,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    SHOW   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] sw_s1_q, sw_s2_q;
  logic       key_s1_q, key_s2_q;
  logic       key_lvl_q, key_lvl_d;
  logic [1:0] prime_q;
  logic       arm_q, arm_d;
  logic [3:0] a0_q, a0_d, a1_q, a1_d;
  logic       s_q, s_d, valid_q, valid_d, done_q, done_d;
  logic       press;

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    key_lvl_d = key_lvl_q;
    cnt_d     = '0;
    if (key_s2_q != key_lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) key_lvl_d = key_s2_q;
      else                               cnt_d     = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_dc;
  assign unused_dc = 32'(DEBOUNCE_CYCLES);

  always_comb begin
    key_lvl_d = key_s2_q;
  end
`endif

  // After reset the key must first be seen released (through a fully post-reset
  // synchronizer sample) before any falling edge counts as a press.
  always_comb begin
    arm_d = arm_q | (prime_q[1] & key_s2_q & key_lvl_q);
    press = arm_q & key_lvl_q & ~key_lvl_d;
  end

  always_comb begin
    state_d = state_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    s_d     = s_q;
    if (press) begin
      case (state_q)
        GET_A:   begin a0_d = sw_s2_q;    state_d = GET_B;  end
        GET_B:   begin a1_d = sw_s2_q;    state_d = GET_OP; end
        GET_OP:  begin s_d  = sw_s2_q[0]; state_d = SHOW;   end
        default: state_d = GET_A;
      endcase
    end
    valid_d = (state_d == SHOW);
    done_d  = (state_d == SHOW) && (state_q != SHOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      key_s1_q  <= 1'b1;
      key_s2_q  <= 1'b1;
      key_lvl_q <= 1'b1;
      prime_q   <= '0;
      arm_q     <= 1'b0;
      state_q   <= GET_A;
      a0_q      <= '0;
      a1_q      <= '0;
      s_q       <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      key_s1_q  <= key_n;
      key_s2_q  <= key_s1_q;
      key_lvl_q <= key_lvl_d;
      prime_q   <= {prime_q[0], 1'b1};
      arm_q     <= arm_d;
      state_q   <= state_d;
      a0_q      <= a0_d;
      a1_q      <= a1_d;
      s_q       <= s_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign a0    = a0_q;
  assign a1    = a1_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm: press sequences, bounce, hold, reset mid-entry and wrap,
// with captures checked against a scoreboard queue of model results.
module tb_operand_entry_fsm;

  localparam int DC = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       key_n = 1'b1;
  logic [3:0] a0, a1;
  logic       s, valid, done;
  logic [1:0] state;

  operand_entry_fsm #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sw(sw), .key_n(key_n),
    .a0(a0), .a1(a1), .s(s), .valid(valid), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];
  logic [1:0] m_state = 2'd0;
  logic [3:0] m_a0 = 4'd0, m_a1 = 4'd0;
  logic       m_s = 1'b0;
  logic [1:0] prev_state;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_a0 = 4'd0; m_a1 = 4'd0; m_s = 1'b0;
  endtask

  // Advance the model by one press and queue the outputs it should produce.
  task automatic push_press(input logic [3:0] v);
    case (m_state)
      2'd0:    m_a0 = v;
      2'd1:    m_a1 = v;
      2'd2:    m_s  = v[0];
      default: ;
    endcase
    m_state = m_state + 2'd1;
    exp_q.push_back({m_state, m_a0, m_a1, m_s, m_state == 2'd3, m_state == 2'd3});
  endtask

  task automatic press(input logic [3:0] v);
    logic [1:0] old;
    old = m_state;
    sw = v;
    tick(4);
    push_press(v);
    key_n = 1'b0;
    repeat (LAT) @(posedge clk);
    #1 check("pre_capture_state", {11'b0, state}, {11'b0, old});
    @(posedge clk);
    #1 check("capture_state", {11'b0, state}, {11'b0, m_state});
    sw = 4'($urandom_range(0, 15));
    tick(3);
    key_n = 1'b1;
    tick(LAT + 4);
  endtask

  // Monitor: valid/done relations every cycle, scoreboard pop on each state change.
  initial begin
    prev_state = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("valid_vs_state", {12'b0, valid}, {12'b0, state == 2'd3});
        check("done_pulse", {12'b0, done}, {12'b0, (state == 2'd3) && (prev_state != 2'd3)});
        if (state !== prev_state) begin
          if (exp_q.size() == 0)
            check("unexpected_advance", {11'b0, state}, {11'b0, prev_state});
          else
            check("capture_sb", {state, a0, a1, s, valid, done}, exp_q.pop_front());
        end
      end
      prev_state = state;
    end
  end

  initial begin
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {state, a0, a1, s, valid, done}, 13'd0);

    press(4'd5);
    press(4'd2);
    press(4'd1);
    check("full_entry", {state, a0, a1, s, valid, done}, {2'd3, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0});

    press(4'd7);
    check("wrap_retain", {state, a0, a1, s, valid, done}, {2'd0, 4'd5, 4'd2, 1'b1, 1'b0, 1'b0});
    press(4'd8);
    check("partial_retain", {state, a0, a1, s, valid, done}, {2'd1, 4'd8, 4'd2, 1'b1, 1'b0, 1'b0});
    press(4'd3);
    press(4'd1);
    press(4'd0);
    check("wrap_831", {state, a0, a1, s, valid, done}, {2'd0, 4'd8, 4'd3, 1'b1, 1'b0, 1'b0});

    sw = 4'd6;
    tick(4);
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    push_press(4'd6);
`else
    for (int i = 0; i < 4; i++) push_press(4'd6);
`endif
    for (int i = 0; i < 3; i++) begin
      key_n = 1'b0; tick(2);
      key_n = 1'b1; tick(2);
    end
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(LAT + 4);
    check("bounce_state", {11'b0, state}, {11'b0, m_state});

    sw = 4'hA;
    tick(4);
    push_press(4'hA);
    key_n = 1'b0;
    tick(100);
    key_n = 1'b1;
    tick(LAT + 4);
    check("hold_state", {11'b0, state}, {11'b0, m_state});

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(2);
    press(4'd9);
    check("mid_a0", {9'b0, a0}, 13'd9);
    rst = 1'b1;
    key_n = 1'b0;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(20 + DC);
    check("mid_reset_no_capture", {state, a0, a1, s, valid, done}, 13'd0);
    key_n = 1'b1;
    tick(LAT + 4);
    press(4'd3);
    check("after_rearm", {state, a0, a1, s, valid, done}, {2'd1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0});

    tick(10);
    check("queue_drained", 13'(exp_q.size()), 13'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
